// File: rtl/mfb_pkt_len_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mfb_pkt_len_gen_pkg
// Description : Shared types and constants for the MFB packet length
//               generator: FSM state encoding, length-field width helper and
//               bit offsets of the {ERR, META, LEN} output item.
// Revision    : 1.0 - initial release
// ============================================================================
package mfb_pkt_len_gen_pkg;

  // Packet-tracking state: outside a packet, or between SOF and EOF
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  // LEN occupies the least significant bits of an output item
  localparam int ITEM_LEN_LSB = 0;

  // Bits needed to hold a length in the range 0..mtu
  function automatic int calc_lw(input int mtu);
    return $clog2(mtu + 1);
  endfunction

  // META sits directly above LEN
  function automatic int item_meta_lsb(input int lw);
    return ITEM_LEN_LSB + lw;
  endfunction

  // ERR is the most significant bit, above META
  function automatic int item_err_bit(input int lw, input int meta_w);
    return ITEM_LEN_LSB + lw + meta_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mfb_pkt_len_gen_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mfb_pkt_len_gen_fifo
// Description : First-word-fall-through FIFO for finished packet headers.
//               The head entry is presented on o_data while not empty; the
//               output reads zero when empty. DEPTH must be a power of two.
// Revision    : 1.0 - initial release
// ============================================================================
module mfb_pkt_len_gen_fifo
  import mfb_pkt_len_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents need no reset because the output is gated by empty
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count is unchanged on push-and-pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mfb_pkt_len_gen.sv
`default_nettype none
// ============================================================================
// Module      : mfb_pkt_len_gen
// Description : Measures packet lengths on a single-region MFB stream and
//               emits one {ERR, META, LEN} MVB item per packet. Lengths
//               saturate at PKT_MTU with ERR set. Optional protocol-error
//               counter enabled by macro MFB_PKT_LEN_GEN_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mfb_pkt_len_gen
  import mfb_pkt_len_gen_pkg::*;
#(
  parameter int REGION_SIZE = 8,
  parameter int BLOCK_SIZE  = 8,
  parameter int ITEM_WIDTH  = 8,
  parameter int META_WIDTH  = 8,
  parameter int PKT_MTU     = 16383,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                                        CLK,
  input  logic                                        RESET_N,
  input  logic [REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] RX_MFB_DATA,
  input  logic [META_WIDTH-1:0]                       RX_MFB_META,
  input  logic                                        RX_MFB_SOF,
  input  logic                                        RX_MFB_EOF,
  input  logic [$clog2(REGION_SIZE)-1:0]              RX_MFB_SOF_POS,
  input  logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]   RX_MFB_EOF_POS,
  input  logic                                        RX_MFB_SRC_RDY,
  output logic                                        RX_MFB_DST_RDY,
  output logic [calc_lw(PKT_MTU)+META_WIDTH:0]        TX_MVB_DATA,
  output logic                                        TX_MVB_VLD,
  output logic                                        TX_MVB_SRC_RDY,
  input  logic                                        TX_MVB_DST_RDY,
  output logic [31:0]                                 ERR_CNT
);

  localparam int          LW       = calc_lw(PKT_MTU);
  localparam int          DW       = 1 + META_WIDTH + LW;
  localparam int          META_LSB = item_meta_lsb(LW);
  localparam int          ERR_BIT  = item_err_bit(LW, META_WIDTH);
  localparam int unsigned W_U      = REGION_SIZE * BLOCK_SIZE;
  localparam int unsigned BS_U     = BLOCK_SIZE;
  localparam int unsigned MTU_U    = PKT_MTU;

  pkt_state_e             r_state;
  logic [LW-1:0]          r_acc;
  logic                   r_ovf;
  logic [META_WIDTH-1:0]  r_meta;
  logic                   r_rdy_en;

  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_single;
  int unsigned            w_s;
  int unsigned            w_e1;
  int unsigned            w_first;
  int unsigned            w_mid;
  int unsigned            w_close;
  logic                   w_first_ovf;
  logic                   w_mid_ovf;
  logic                   w_close_ovf;
  logic [LW-1:0]          w_first_len;
  logic [LW-1:0]          w_mid_len;
  logic [LW-1:0]          w_close_len;
  logic [DW-1:0]          w_item;

  assign w_accept       = RX_MFB_SRC_RDY & RX_MFB_DST_RDY;
  assign RX_MFB_DST_RDY = r_rdy_en & ~w_full;
  assign TX_MVB_SRC_RDY = ~w_empty;
  assign TX_MVB_VLD     = ~w_empty;
  assign w_pop          = ~w_empty & TX_MVB_DST_RDY;
  // An item is produced by any EOF inside a packet, or a self-contained word
  assign w_push = w_accept & RX_MFB_EOF &
                  ((r_state == IN_PKT) | (RX_MFB_SOF & w_single));

  // Per-word length contributions with saturation against PKT_MTU
  always_comb begin
    w_s         = 32'(RX_MFB_SOF_POS) * BS_U;
    w_e1        = 32'(RX_MFB_EOF_POS) + 32'd1;
    w_single    = (w_s < w_e1);
    w_first     = W_U - w_s;
    w_mid       = 32'(r_acc) + W_U;
    w_close     = (r_state == IN_PKT) ? (32'(r_acc) + w_e1) : (w_e1 - w_s);
    w_first_ovf = (w_first > MTU_U);
    w_mid_ovf   = (w_mid > MTU_U);
    w_close_ovf = (w_close > MTU_U) | ((r_state == IN_PKT) & r_ovf);
    w_first_len = w_first_ovf ? LW'(MTU_U) : LW'(w_first);
    w_mid_len   = w_mid_ovf ? LW'(MTU_U) : LW'(w_mid);
    w_close_len = (w_close > MTU_U) ? LW'(MTU_U) : LW'(w_close);
    w_item      = '0;
    w_item[ITEM_LEN_LSB +: LW]     = w_close_len;
    w_item[META_LSB +: META_WIDTH] = (r_state == IN_PKT) ? r_meta : RX_MFB_META;
    w_item[ERR_BIT]                = w_close_ovf;
  end

  // Packet FSM with accumulator, overflow flag and latched metadata
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_meta   <= '0;
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        case (r_state)
          IDLE: begin
            // A SOF that does not close in this word opens a packet
            if (RX_MFB_SOF && !(RX_MFB_EOF && w_single)) begin
              r_state <= IN_PKT;
              r_acc   <= w_first_len;
              r_ovf   <= w_first_ovf;
              r_meta  <= RX_MFB_META;
            end
          end
          IN_PKT: begin
            if (RX_MFB_SOF) begin
              // New packet starts; the old one was either closed or dropped
              r_acc  <= w_first_len;
              r_ovf  <= w_first_ovf;
              r_meta <= RX_MFB_META;
            end else if (RX_MFB_EOF) begin
              r_state <= IDLE;
              r_acc   <= '0;
              r_ovf   <= 1'b0;
            end else begin
              r_acc <= w_mid_len;
              r_ovf <= r_ovf | w_mid_ovf;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  mfb_pkt_len_gen_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_push  (w_push),
    .i_data  (w_item),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_data  (TX_MVB_DATA)
  );

`ifdef MFB_PKT_LEN_GEN_ERR_CNT_EN
  logic        w_proto_err;
  logic [31:0] r_err_cnt;

  assign w_proto_err = w_accept &
      (((r_state == IDLE) & RX_MFB_EOF & ~(RX_MFB_SOF & w_single)) |
       ((r_state == IN_PKT) & RX_MFB_SOF & ~RX_MFB_EOF));
  assign ERR_CNT = r_err_cnt;

  // Saturating count of orphan EOFs and unterminated packets
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_err_cnt <= '0;
    end else if (w_proto_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 32'd1;
    end
  end
`else
  assign ERR_CNT = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mfb_pkt_len_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mfb_pkt_len_gen
// Description : Self-checking bench for mfb_pkt_len_gen (PKT_MTU=256,
//               FIFO_DEPTH=4). Directed literal cases plus random traffic
//               against a packet-level length model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mfb_pkt_len_gen;

  localparam int MTU   = 256;
  localparam int DEPTH = 4;
  localparam int DW    = 18;
`ifdef MFB_PKT_LEN_GEN_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [511:0]  RX_MFB_DATA;
  logic [7:0]    RX_MFB_META;
  logic          RX_MFB_SOF, RX_MFB_EOF;
  logic [2:0]    RX_MFB_SOF_POS;
  logic [5:0]    RX_MFB_EOF_POS;
  logic          RX_MFB_SRC_RDY, RX_MFB_DST_RDY;
  logic [DW-1:0] TX_MVB_DATA;
  logic          TX_MVB_VLD, TX_MVB_SRC_RDY, TX_MVB_DST_RDY;
  logic [31:0]   ERR_CNT;

  always #5 CLK = ~CLK;

  mfb_pkt_len_gen #(
    .REGION_SIZE (8), .BLOCK_SIZE (8), .ITEM_WIDTH (8), .META_WIDTH (8),
    .PKT_MTU (MTU), .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK (CLK), .RESET_N (RESET_N),
    .RX_MFB_DATA (RX_MFB_DATA), .RX_MFB_META (RX_MFB_META),
    .RX_MFB_SOF (RX_MFB_SOF), .RX_MFB_EOF (RX_MFB_EOF),
    .RX_MFB_SOF_POS (RX_MFB_SOF_POS), .RX_MFB_EOF_POS (RX_MFB_EOF_POS),
    .RX_MFB_SRC_RDY (RX_MFB_SRC_RDY), .RX_MFB_DST_RDY (RX_MFB_DST_RDY),
    .TX_MVB_DATA (TX_MVB_DATA), .TX_MVB_VLD (TX_MVB_VLD),
    .TX_MVB_SRC_RDY (TX_MVB_SRC_RDY), .TX_MVB_DST_RDY (TX_MVB_DST_RDY),
    .ERR_CNT (ERR_CNT)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- packet-level reference model -------------------------
  logic [DW-1:0] mq[$];
  logic [DW-1:0] popped[$];
  bit            m_in_pkt, m_started, m_acc, m_pop, m_have, exp_dst;
  int            m_len, m_err, s, e;
  logic [7:0]    m_meta;
  logic [DW-1:0] m_item;

  function automatic logic [DW-1:0] mk_item(input int len, input logic [7:0] meta);
    if (len > MTU) return {1'b1, meta, 9'(MTU)};
    return {1'b0, meta, 9'(len)};
  endfunction

  initial begin
    forever begin
      @(negedge CLK);
      if (!RESET_N) begin
        mq.delete(); m_in_pkt = 0; m_len = 0; m_err = 0; m_started = 0;
      end
      exp_dst = m_started && (mq.size() < DEPTH);
      check("rx_dst_rdy", {31'd0, RX_MFB_DST_RDY}, {31'd0, exp_dst});
      check("tx_src_rdy", {31'd0, TX_MVB_SRC_RDY}, {31'd0, mq.size() != 0});
      check("tx_vld", {31'd0, TX_MVB_VLD}, {31'd0, mq.size() != 0});
      check("tx_data", 32'(TX_MVB_DATA), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      check("err_cnt", ERR_CNT, ERR_EN ? m_err : 0);
      if (RESET_N) begin
        if (TX_MVB_SRC_RDY && TX_MVB_DST_RDY) popped.push_back(TX_MVB_DATA);
        m_acc  = RX_MFB_SRC_RDY && exp_dst;
        m_pop  = (mq.size() != 0) && TX_MVB_DST_RDY;
        m_have = 0;
        if (m_acc) begin
          s = int'(RX_MFB_SOF_POS) * 8;
          e = int'(RX_MFB_EOF_POS);
          if (!m_in_pkt) begin
            if (RX_MFB_SOF && RX_MFB_EOF && s <= e) begin
              m_item = mk_item(e - s + 1, RX_MFB_META); m_have = 1;
            end else begin
              if (RX_MFB_EOF) m_err++;
              if (RX_MFB_SOF) begin m_in_pkt = 1; m_len = 64 - s; m_meta = RX_MFB_META; end
            end
          end else if (RX_MFB_EOF) begin
            m_item = mk_item(m_len + e + 1, m_meta); m_have = 1;
            if (RX_MFB_SOF) begin m_len = 64 - s; m_meta = RX_MFB_META; end
            else m_in_pkt = 0;
          end else if (RX_MFB_SOF) begin
            m_err++; m_len = 64 - s; m_meta = RX_MFB_META;
          end else begin
            m_len += 64;
          end
        end
        if (m_pop) void'(mq.pop_front());
        if (m_have) mq.push_back(m_item);
        m_started = 1;
      end
    end
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic idle_in();
    RX_MFB_SRC_RDY = 0; RX_MFB_SOF = 0; RX_MFB_EOF = 0;
  endtask

  task automatic send(input bit sof, input bit eof, input int sp, input int ep, input logic [7:0] meta);
    bit got = 0;
    RX_MFB_SOF = sof; RX_MFB_EOF = eof;
    RX_MFB_SOF_POS = 3'(sp); RX_MFB_EOF_POS = 6'(ep);
    RX_MFB_META = meta; RX_MFB_DATA = {16{$urandom()}};
    RX_MFB_SRC_RDY = 1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge CLK); got = RX_MFB_DST_RDY;
      @(posedge CLK); #1;
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
    idle_in();
  endtask

  task automatic pop_one();
    TX_MVB_DST_RDY = 1; cyc(1); TX_MVB_DST_RDY = 0;
  endtask

  // ---------------- main sequence ----------------------------------------
  initial begin
    RESET_N = 0; TX_MVB_DST_RDY = 0; RX_MFB_DATA = '0; RX_MFB_META = '0;
    RX_MFB_SOF_POS = '0; RX_MFB_EOF_POS = '0; idle_in();
    cyc(2);
    check("rst_dst_rdy", {31'd0, RX_MFB_DST_RDY}, 32'd0);
    check("rst_tx_src_rdy", {31'd0, TX_MVB_SRC_RDY}, 32'd0);
    check("rst_tx_data", 32'(TX_MVB_DATA), 32'd0);
    check("rst_err_cnt", ERR_CNT, 32'd0);
    RESET_N = 1;
    cyc(1);
    check("dst_rdy_after_release", {31'd0, RX_MFB_DST_RDY}, 32'd1);

    // single-word packet, latency 1
    send(1, 1, 0, 59, 8'h11);
    check("single_vld", {31'd0, TX_MVB_VLD}, 32'd1);
    check("single_len60", 32'(TX_MVB_DATA), 32'({1'b0, 8'h11, 9'd60}));
    pop_one();

    // multi-word packet: 48 + 64 + 64 + 24
    send(1, 0, 2, 0, 8'h22); send(0, 0, 0, 0, 8'h00);
    send(0, 0, 0, 0, 8'h00); send(0, 1, 0, 23, 8'h00);
    check("multi_len200", 32'(TX_MVB_DATA), 32'({1'b0, 8'h22, 9'd200}));
    pop_one();

    // EOF closes and SOF reopens in one word
    send(1, 0, 0, 0, 8'h33);
    send(1, 1, 4, 15, 8'h44);
    check("close_open_first", 32'(TX_MVB_DATA), 32'({1'b0, 8'h33, 9'd80}));
    pop_one();
    send(0, 1, 0, 31, 8'h00);
    check("close_open_second", 32'(TX_MVB_DATA), 32'({1'b0, 8'h44, 9'd64}));
    pop_one();

    // 300-item packet saturates
    send(1, 0, 0, 0, 8'h55);
    repeat (3) send(0, 0, 0, 0, 8'h00);
    send(0, 1, 0, 43, 8'h00);
    check("mtu_sat", 32'(TX_MVB_DATA), 32'({1'b1, 8'h55, 9'd256}));
    pop_one();

    // back-pressure: 4 queued, fifth held
    for (int i = 0; i < 4; i++) send(1, 1, 0, i, 8'(8'h60 + i));
    check("full_dst_rdy", {31'd0, RX_MFB_DST_RDY}, 32'd0);
    RX_MFB_SOF = 1; RX_MFB_EOF = 1; RX_MFB_SOF_POS = 0; RX_MFB_EOF_POS = 4;
    RX_MFB_META = 8'h64; RX_MFB_SRC_RDY = 1;
    cyc(3);
    check("held_dst_rdy", {31'd0, RX_MFB_DST_RDY}, 32'd0);
    check("held_head", 32'(TX_MVB_DATA), 32'({1'b0, 8'h60, 9'd1}));
    popped.delete();
    TX_MVB_DST_RDY = 1;
    send(1, 1, 0, 4, 8'h64);
    cyc(10);
    check("drain_count", popped.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      check("drain_order", (i < popped.size()) ? 32'(popped[i]) : 32'hdead,
            32'({1'b0, 8'(8'h60 + i), 9'(i + 1)}));

    // orphan EOF in IDLE
    send(0, 1, 0, 10, 8'h00);
    cyc(1);
    check("orphan_err_cnt", ERR_CNT, ERR_EN ? 32'd1 : 32'd0);
    check("orphan_no_item", {31'd0, TX_MVB_SRC_RDY}, 32'd0);

    // random traffic, two EOF densities
    for (int i = 0; i < 4000; i++) begin
      RX_MFB_SRC_RDY = ($urandom_range(0, 3) != 0);
      RX_MFB_SOF     = ($urandom_range(0, 3) == 0);
      RX_MFB_EOF     = (i < 2500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      RX_MFB_SOF_POS = 3'($urandom_range(0, 7));
      RX_MFB_EOF_POS = 6'($urandom_range(0, 63));
      RX_MFB_META    = 8'($urandom());
      RX_MFB_DATA    = {16{$urandom()}};
      TX_MVB_DST_RDY = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    idle_in(); TX_MVB_DST_RDY = 1;
    cyc(10);

    // reset mid-packet with queued items
    TX_MVB_DST_RDY = 0;
    send(1, 1, 0, 5, 8'h70);
    send(1, 0, 0, 0, 8'h71);
    RESET_N = 0;
    #1;
    check("midrst_tx_src_rdy", {31'd0, TX_MVB_SRC_RDY}, 32'd0);
    check("midrst_dst_rdy", {31'd0, RX_MFB_DST_RDY}, 32'd0);
    cyc(1); RESET_N = 1; cyc(2);
    send(0, 1, 0, 9, 8'h00);
    check("midrst_partial_gone", {31'd0, TX_MVB_SRC_RDY}, 32'd0);
    send(1, 1, 0, 9, 8'h72);
    check("midrst_fresh", 32'(TX_MVB_DATA), 32'({1'b0, 8'h72, 9'd10}));
    check("midrst_err_cnt", ERR_CNT, ERR_EN ? 32'd1 : 32'd0);
    cyc(2);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
